mac_output_drain: RTL and testbench

- Reads accumulated results from a row of `mac` units and returns them to the host side as a serial stream.
- On a `capture` pulse, snapshots all `NUM_MACS` accumulator values into an internal buffer.
- Each value is then scaled by arithmetic right shift and saturated to `OUTPUT_WIDTH`.
- Values are emitted one per accepted beat over a valid/ready interface, in index order, with `out_last` on the final beat.

---
 rtl/mac_drain_pkg.sv | 14 +
 rtl/mac_output_drain_if.sv | 22 ++
 rtl/output_saturator.sv | 27 ++
 rtl/mac_output_drain.sv | 101 ++++++++++
 tb/tb_mac_output_drain.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_drain_pkg.sv
// Shared types and helpers for the MAC output drain.
package mac_drain_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  // Bits needed to index one entry of a snapshot.
  function automatic int unsigned index_width(input int unsigned num_macs);
    return $clog2(num_macs);
  endfunction

endpackage

// File: rtl/mac_output_drain_if.sv
// Valid/ready result stream from the drain to the host side.
interface mac_output_drain_if #(
  parameter int unsigned OUTPUT_WIDTH = 16,
  parameter int unsigned INDEX_WIDTH  = 2
);
  logic                    out_valid;
  logic                    out_ready;
  logic [OUTPUT_WIDTH-1:0] out_data;
  logic [INDEX_WIDTH-1:0]  out_index;
  logic                    out_last;
  logic                    out_saturated;

  modport master (
    output out_valid, out_data, out_index, out_last, out_saturated,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_index, out_last, out_saturated,
    output out_ready
  );
endinterface

// File: rtl/output_saturator.sv
// Arithmetic right shift followed by signed saturation to OUT_WIDTH.
module output_saturator #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned SCALE     = 0
) (
  input  logic signed [IN_WIDTH-1:0]  value_in,
  output logic signed [OUT_WIDTH-1:0] value_out,
  output logic                        clipped
);
  logic signed [IN_WIDTH-1:0]     shifted;
  logic [IN_WIDTH-OUT_WIDTH:0]    upper;

  assign shifted = value_in >>> SCALE;
  // The value fits iff every bit above the output sign bit copies it.
  assign upper   = shifted[IN_WIDTH-1:OUT_WIDTH-1];

  // Pass through in range, otherwise clamp to the nearest representable extreme.
  always_comb begin
    clipped   = !((upper == '0) || (&upper));
    value_out = shifted[OUT_WIDTH-1:0];
    if (clipped) begin
      value_out = shifted[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                      : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end
endmodule

// File: rtl/mac_output_drain.sv
// Snapshots a row of MAC accumulators and streams them out scaled and saturated.
module mac_output_drain
  import mac_drain_pkg::*;
#(
  parameter int unsigned NUM_MACS          = 4,
  parameter int unsigned ACCUMULATOR_WIDTH = 32,
  parameter int unsigned OUTPUT_WIDTH      = 16,
  parameter int unsigned OUTPUT_SCALE      = 0
) (
  input  logic                                  clk,
  input  logic                                  arst_n_in,
  input  logic                                  capture,
  input  logic [NUM_MACS*ACCUMULATOR_WIDTH-1:0] mac_acc,
  output logic                                  capture_ready,
  mac_output_drain_if.master                    out_if
);
  localparam int unsigned INDEX_WIDTH = index_width(NUM_MACS);
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_MACS - 1);

  drain_state_e                   state_q, state_d;
  logic [INDEX_WIDTH-1:0]         idx_q, idx_d;
  logic                           idx_en;
  logic                           buf_en;
  logic signed [ACCUMULATOR_WIDTH-1:0] buf_q [NUM_MACS];
  logic signed [ACCUMULATOR_WIDTH-1:0] sel_entry;
  logic signed [OUTPUT_WIDTH-1:0] sat_data;
  logic                           sat_clipped;

  // Next-state, index update and handshake flags.
  always_comb begin
    state_d             = state_q;
    idx_d               = idx_q;
    idx_en              = 1'b0;
    buf_en              = 1'b0;
    capture_ready       = 1'b0;
    out_if.out_valid    = 1'b0;
    unique case (state_q)
      IDLE: begin
        capture_ready = 1'b1;
        if (capture) begin
          buf_en  = 1'b1;
          idx_en  = 1'b1;
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        out_if.out_valid = 1'b1;
        if (out_if.out_ready) begin
          idx_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + INDEX_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Beat index register.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)  idx_q <= '0;
    else if (idx_en) idx_q <= idx_d;
  end

  // Snapshot buffer; loaded only in the capture cycle.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int i = 0; i < int'(NUM_MACS); i++) buf_q[i] <= '0;
    end else if (buf_en) begin
      for (int i = 0; i < int'(NUM_MACS); i++)
        buf_q[i] <= mac_acc[i*ACCUMULATOR_WIDTH +: ACCUMULATOR_WIDTH];
    end
  end

  assign sel_entry = buf_q[idx_q];

  output_saturator #(
    .IN_WIDTH  (ACCUMULATOR_WIDTH),
    .OUT_WIDTH (OUTPUT_WIDTH),
    .SCALE     (OUTPUT_SCALE)
  ) u_sat (
    .value_in  (sel_entry),
    .value_out (sat_data),
    .clipped   (sat_clipped)
  );

  assign out_if.out_data      = sat_data;
  assign out_if.out_saturated = sat_clipped;
  assign out_if.out_index     = idx_q;
  assign out_if.out_last      = (state_q == DRAIN) && (idx_q == LAST_IDX);
endmodule

// File: tb/tb_mac_output_drain.sv
// Randomized bench for mac_output_drain against a plain-arithmetic reference.
module tb_mac_output_drain;
  localparam int NM = 4;
  localparam int AW = 32;
  localparam int OW = 16;
  localparam int IW = 2;
  localparam int SC = 4;

  typedef struct {
    logic [OW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
    logic          sat;
  } beat_t;

  logic              clk;
  logic              arst_n_in;
  logic              capture;
  logic [NM*AW-1:0]  mac_acc;
  logic              capture_ready;

  mac_output_drain_if #(.OUTPUT_WIDTH(OW), .INDEX_WIDTH(IW)) dif ();

  mac_output_drain #(
    .NUM_MACS(NM), .ACCUMULATOR_WIDTH(AW), .OUTPUT_WIDTH(OW), .OUTPUT_SCALE(SC)
  ) dut (
    .clk           (clk),
    .arst_n_in     (arst_n_in),
    .capture       (capture),
    .mac_acc       (mac_acc),
    .capture_ready (capture_ready),
    .out_if        (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  beat_t got[$];
  int    stall_bad;
  int    timed_out;
  int    drain_cycles;

  // Reference: floor-divide by 2^SC, then clamp into the signed OW range.
  function automatic beat_t model_beat(input logic [NM*AW-1:0] acc, input int i);
    beat_t   b;
    logic [AW-1:0] raw;
    longint  v;
    longint  s;
    raw = acc[i*AW +: AW];
    v   = longint'(signed'(raw));
    s   = v >>> SC;
    b.idx  = IW'(i);
    b.last = (i == NM - 1);
    if (s > 32767) begin
      b.data = 16'h7FFF; b.sat = 1'b1;
    end else if (s < -32768) begin
      b.data = 16'h8000; b.sat = 1'b1;
    end else begin
      b.data = OW'(s); b.sat = 1'b0;
    end
    return b;
  endfunction

  function automatic logic [AW-1:0] rand_entry();
    logic [AW-1:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: rand_entry = r;
      1: rand_entry = {{12{r[19]}}, r[19:0]};
      2: rand_entry = 32'h0007_FFF0 + AW'($urandom_range(0, 31));
      3: rand_entry = 32'hFFF8_0000 - AW'($urandom_range(0, 31));
      default: rand_entry = {{16{r[15]}}, r[15:0]};
    endcase
  endfunction

  function automatic logic [NM*AW-1:0] rand_acc();
    logic [NM*AW-1:0] a;
    for (int i = 0; i < NM; i++) a[i*AW +: AW] = rand_entry();
    return a;
  endfunction

  // Presents a capture for one edge; afterwards mac_acc changes to junk.
  task automatic do_capture(input logic [NM*AW-1:0] acc);
    mac_acc = acc;
    capture = 1'b1;
    @(posedge clk); #1;
    capture = 1'b0;
    mac_acc = rand_acc();
  endtask

  // Drives out_ready (0: always, 1: 1,0,0,1 pattern, 2: random) and records
  // accepted beats. Called and returns at posedge+1.
  task automatic run_drain(input int mode, input int stop_after,
                           input int inject_cycle, input logic [NM*AW-1:0] inject_acc);
    logic          rdy;
    logic          stalled;
    logic [OW-1:0] held;
    int            cyc;
    beat_t         b;
    got.delete();
    stall_bad = 0;
    timed_out = 0;
    stalled   = 1'b0;
    held      = '0;
    cyc       = 0;
    while (got.size() < stop_after) begin
      if (cyc > 200) begin
        timed_out = 1;
        break;
      end
      if (stalled && (dif.out_data !== held)) stall_bad++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (cyc == inject_cycle) begin
        mac_acc = inject_acc;
        capture = 1'b1;
      end else begin
        capture = 1'b0;
      end
      if (dif.out_valid && rdy) begin
        b.data = dif.out_data; b.idx = dif.out_index;
        b.last = dif.out_last; b.sat = dif.out_saturated;
        got.push_back(b);
      end
      stalled       = dif.out_valid && !rdy;
      held          = dif.out_data;
      dif.out_ready = rdy;
      @(posedge clk); #1;
      cyc++;
    end
    dif.out_ready = 1'b0;
    capture       = 1'b0;
    drain_cycles  = cyc;
  endtask

  task automatic test_reset();
    arst_n_in = 1'b1;
    #3 arst_n_in = 1'b0;
    #1;
    checks++; if (capture_ready !== 1'b1) begin errors++; $display("FAIL reset_capture_ready: got %b want 1", capture_ready); end
    checks++; if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", dif.out_valid); end
    checks++; if (dif.out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h want 0000", dif.out_data); end
    checks++; if (dif.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", dif.out_last); end
    checks++; if (dif.out_saturated !== 1'b0) begin errors++; $display("FAIL reset_out_saturated: got %b want 0", dif.out_saturated); end
    checks++; if (dif.out_index !== 2'd0) begin errors++; $display("FAIL reset_out_index: got %0d want 0", dif.out_index); end
    @(posedge clk); #1;
    arst_n_in = 1'b1;
    @(posedge clk); #1;
    checks++; if (capture_ready !== 1'b1) begin errors++; $display("FAIL post_reset_capture_ready: got %b want 1", capture_ready); end
  endtask

  task automatic test_basic_drain();
    logic [NM*AW-1:0] acc;
    logic [OW-1:0]    want_data [NM];
    beat_t            e;
    acc = {32'h0000_0100, 32'h0007_FFF0, 32'hFFFF_FFC0, 32'h0000_0040};
    want_data[0] = 16'h0004; want_data[1] = 16'hFFFC;
    want_data[2] = 16'h7FFF; want_data[3] = 16'h0010;
    do_capture(acc);
    checks++; if (dif.out_valid !== 1'b1 || dif.out_index !== 2'd0) begin errors++; $display("FAIL basic_latency: valid=%b idx=%0d want 1/0", dif.out_valid, dif.out_index); end
    checks++; if (capture_ready !== 1'b0) begin errors++; $display("FAIL basic_busy: capture_ready=%b want 0", capture_ready); end
    run_drain(0, NM, -1, '0);
    checks++; if (got.size() != NM || timed_out != 0) begin errors++; $display("FAIL basic_count: got %0d beats want %0d", got.size(), NM); end
    checks++; if (drain_cycles != NM) begin errors++; $display("FAIL basic_throughput: got %0d cycles want %0d", drain_cycles, NM); end
    for (int i = 0; i < got.size() && i < NM; i++) begin
      e = model_beat(acc, i);
      checks++; if (got[i].data !== want_data[i] || got[i].sat !== 1'b0) begin errors++; $display("FAIL basic_beat%0d: data=%h sat=%b want %h/0", i, got[i].data, got[i].sat, want_data[i]); end
      checks++; if (got[i].idx !== e.idx || got[i].last !== e.last || got[i].data !== e.data) begin errors++; $display("FAIL basic_model%0d: idx=%0d last=%b data=%h want %0d/%b/%h", i, got[i].idx, got[i].last, got[i].data, e.idx, e.last, e.data); end
    end
    checks++; if (capture_ready !== 1'b1 || dif.out_valid !== 1'b0) begin errors++; $display("FAIL basic_return_idle: capture_ready=%b valid=%b want 1/0", capture_ready, dif.out_valid); end
  endtask

  task automatic test_saturation();
    logic [NM*AW-1:0] acc;
    beat_t            e;
    acc = {rand_entry(), rand_entry(), 32'hFFF7_FFF0, 32'h0008_0000};
    do_capture(acc);
    run_drain(0, NM, -1, '0);
    checks++; if (got.size() != NM) begin errors++; $display("FAIL sat_count: got %0d want %0d", got.size(), NM); end
    if (got.size() == NM) begin
      checks++; if (got[0].data !== 16'h7FFF || got[0].sat !== 1'b1) begin errors++; $display("FAIL sat_pos: data=%h sat=%b want 7fff/1", got[0].data, got[0].sat); end
      checks++; if (got[1].data !== 16'h8000 || got[1].sat !== 1'b1) begin errors++; $display("FAIL sat_neg: data=%h sat=%b want 8000/1", got[1].data, got[1].sat); end
      for (int i = 2; i < NM; i++) begin
        e = model_beat(acc, i);
        checks++; if (got[i].data !== e.data || got[i].sat !== e.sat) begin errors++; $display("FAIL sat_rand%0d: data=%h sat=%b want %h/%b", i, got[i].data, got[i].sat, e.data, e.sat); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [NM*AW-1:0] acc;
    beat_t            e;
    acc = rand_acc();
    do_capture(acc);
    run_drain(1, NM, -1, '0);
    checks++; if (got.size() != NM) begin errors++; $display("FAIL bp_count: got %0d want %0d", got.size(), NM); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stable: %0d unstable stall cycles want 0", stall_bad); end
    for (int i = 0; i < got.size(); i++) begin
      e = model_beat(acc, i);
      checks++; if (got[i].idx !== e.idx || got[i].data !== e.data || got[i].last !== e.last || got[i].sat !== e.sat) begin errors++; $display("FAIL bp_beat%0d: idx=%0d data=%h last=%b sat=%b want %0d/%h/%b/%b", i, got[i].idx, got[i].data, got[i].last, got[i].sat, e.idx, e.data, e.last, e.sat); end
    end
    checks++; if (dif.out_valid !== 1'b0 || capture_ready !== 1'b1) begin errors++; $display("FAIL bp_idle: valid=%b capture_ready=%b want 0/1", dif.out_valid, capture_ready); end
  endtask

  task automatic test_capture_ignored();
    logic [NM*AW-1:0] acc_a;
    logic [NM*AW-1:0] acc_b;
    beat_t            e;
    acc_a = rand_acc();
    acc_b = ~acc_a;
    do_capture(acc_a);
    run_drain(0, NM, 1, acc_b);
    checks++; if (got.size() != NM) begin errors++; $display("FAIL ign_count: got %0d want %0d", got.size(), NM); end
    for (int i = 0; i < got.size(); i++) begin
      e = model_beat(acc_a, i);
      checks++; if (got[i].idx !== e.idx || got[i].data !== e.data || got[i].sat !== e.sat) begin errors++; $display("FAIL ign_beat%0d: idx=%0d data=%h sat=%b want %0d/%h/%b", i, got[i].idx, got[i].data, got[i].sat, e.idx, e.data, e.sat); end
    end
    checks++; if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL ign_idle: valid=%b want 0", dif.out_valid); end
  endtask

  task automatic test_reset_mid_drain();
    logic [NM*AW-1:0] acc;
    beat_t            e;
    do_capture(rand_acc());
    run_drain(0, 2, -1, '0);
    #2 arst_n_in = 1'b0;
    #1;
    checks++; if (dif.out_valid !== 1'b0 || capture_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_async: valid=%b capture_ready=%b want 0/1", dif.out_valid, capture_ready); end
    checks++; if (dif.out_data !== 16'h0000 || dif.out_index !== 2'd0) begin errors++; $display("FAIL mid_reset_outputs: data=%h idx=%0d want 0000/0", dif.out_data, dif.out_index); end
    @(posedge clk); #1;
    arst_n_in = 1'b1;
    @(posedge clk); #1;
    checks++; if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_no_beat: valid=%b want 0", dif.out_valid); end
    acc = rand_acc();
    do_capture(acc);
    run_drain(0, NM, -1, '0);
    checks++; if (got.size() != NM) begin errors++; $display("FAIL mid_reset_count: got %0d want %0d", got.size(), NM); end
    for (int i = 0; i < got.size(); i++) begin
      e = model_beat(acc, i);
      checks++; if (got[i].idx !== e.idx || got[i].data !== e.data || got[i].last !== e.last) begin errors++; $display("FAIL mid_reset_beat%0d: idx=%0d data=%h last=%b want %0d/%h/%b", i, got[i].idx, got[i].data, got[i].last, e.idx, e.data, e.last); end
    end
  endtask

  task automatic test_random_back_to_back();
    logic [NM*AW-1:0] acc;
    beat_t            e;
    for (int r = 0; r < 20; r++) begin
      acc = rand_acc();
      do_capture(acc);
      run_drain(2, NM, -1, '0);
      checks++; if (got.size() != NM || stall_bad != 0) begin errors++; $display("FAIL rand%0d_count: beats=%0d unstable=%0d want %0d/0", r, got.size(), stall_bad, NM); end
      for (int i = 0; i < got.size(); i++) begin
        e = model_beat(acc, i);
        checks++; if (got[i].idx !== e.idx || got[i].data !== e.data || got[i].last !== e.last || got[i].sat !== e.sat) begin errors++; $display("FAIL rand%0d_beat%0d: idx=%0d data=%h last=%b sat=%b want %0d/%h/%b/%b", r, i, got[i].idx, got[i].data, got[i].last, got[i].sat, e.idx, e.data, e.last, e.sat); end
      end
    end
  endtask

  initial begin
    arst_n_in     = 1'b1;
    capture       = 1'b0;
    mac_acc       = '0;
    dif.out_ready = 1'b0;
    test_reset();
    test_basic_drain();
    test_saturation();
    test_backpressure();
    test_capture_ignored();
    test_reset_mid_drain();
    test_random_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
